// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, branch flushes, memory-wait
// freezing with a watchdog, halt sequencing and a saturating stall counter.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       Rd1Addr_IFID,
  input  logic [2:0]       Rd2Addr_IFID,
  input  logic             rd1Used,
  input  logic             rd2Used,
  input  logic [2:0]       WrR_IDEX,
  input  logic             RegWrite_IDEX,
  input  logic             MemRead_IDEX,
  input  logic             takeBranch_EXMEM,
  input  logic             memBusy,
  input  logic             halt_MEMWB,
  output logic             stallCtrl,
  output logic             freeze,
  output logic             pcEn,
  output logic             flush,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] stallCount
);

  typedef enum logic [1:0] {StRun, StMemWait, StHalt} state_e;

  localparam logic [7:0] TimeoutVal = 8'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             pend_flush_q, pend_flush_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             load_use;
  logic             stall_event;

  assign load_use = MemRead_IDEX & RegWrite_IDEX &
                    ((rd1Used & (Rd1Addr_IFID == WrR_IDEX)) |
                     (rd2Used & (Rd2Addr_IFID == WrR_IDEX)));

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    pend_flush_d = pend_flush_q;
    err_d        = err_q;
    stallCtrl    = 1'b0;
    flush        = 1'b0;
    freeze       = 1'b1;
    pcEn         = 1'b1;
    unique case (state_q)
      // MEMWAIT with memBusy low behaves exactly like RUN, giving zero exit latency.
      StRun, StMemWait: begin
        if (halt_MEMWB) begin
          state_d = StHalt;
          freeze  = 1'b0;
          pcEn    = 1'b0;
        end else if (memBusy) begin
          freeze  = 1'b0;
          pcEn    = 1'b0;
          state_d = StMemWait;
          if (state_q == StRun) begin
            pend_flush_d = pend_flush_q | takeBranch_EXMEM;
            wait_cnt_d   = '0;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
            if (wait_cnt_d == TimeoutVal) begin
              err_d   = 1'b1;
              state_d = StHalt;
            end
          end
        end else begin
          state_d      = StRun;
          wait_cnt_d   = '0;
          pend_flush_d = 1'b0;
          if (takeBranch_EXMEM || pend_flush_q) begin
            flush     = 1'b1;
            stallCtrl = 1'b1;
          end else if (load_use) begin
            stallCtrl = 1'b1;
            pcEn      = 1'b0;
          end
        end
      end
      StHalt: begin
        freeze = 1'b0;
        pcEn   = 1'b0;
      end
      default: state_d = StRun;
    endcase
    if (rst) begin
      stallCtrl = 1'b0;
      flush     = 1'b0;
      freeze    = 1'b1;
      pcEn      = 1'b1;
    end
  end

  assign stall_event = (~freeze | stallCtrl) & (state_q != StHalt);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_event && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StRun;
      wait_cnt_q   <= '0;
      pend_flush_q <= 1'b0;
      err_q        <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      pend_flush_q <= pend_flush_d;
      err_q        <= err_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign halted     = (state_q == StHalt);
  assign err        = err_q;
  assign stallCount = stall_cnt_q;

endmodule
